// File: rtl/lamp_stretch.sv
// lamp_stretch -- front-panel lamp output conditioner.
//
// Stretches single-cycle internal events into lamp drive pulses long
// enough to be seen. A shared DIV_W-bit prescaler produces a slow tick.
// Each channel has a retriggerable hold counter that is reloaded with
// HOLD on an event and decremented once per tick until it reaches zero.
//
// Optional feature: define LAMP_PWM_EN to add a 4-bit brightness input
// and a free-running PWM phase counter that gates held lamps.
//
// Parameters:
//   N      number of lamp channels (>=1)
//   DIV_W  prescaler width; tick period is 2^DIV_W clk cycles (>=2)
//   HOLD   hold length in ticks (>=1)
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   evt        [N] per-channel event strobes (the natural name "event"
//              is a SystemVerilog keyword)
//   lamp_test  forces every lamp bit high (one cycle registered)
//   bright     [4] PWM level, present only with LAMP_PWM_EN
//   lamp       [N] registered lamp drive
//   tick       one-cycle prescaler strobe
module lamp_stretch #(
  parameter int N     = 8,
  parameter int DIV_W = 15,
  parameter int HOLD  = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] evt,
  input  logic         lamp_test,
`ifdef LAMP_PWM_EN
  input  logic [3:0]   bright,
`endif
  output logic [N-1:0] lamp,
  output logic         tick
);

  localparam int CW = $clog2(HOLD + 1);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD);

  // Decrement that stops at zero instead of wrapping.
  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic [CW-1:0]    cnt_q [N];
  logic [CW-1:0]    cnt_d [N];
  logic [N-1:0]     lamp_q, lamp_d;
  logic             pwm_gate;

`ifdef LAMP_PWM_EN
  logic [3:0] phase_q, phase_d;

  always_comb begin
    phase_d  = phase_q + 4'd1;
    pwm_gate = (phase_q < bright);
  end
`else
  always_comb begin
    pwm_gate = 1'b1;
  end
`endif

  always_comb begin
    div_d  = div_q + 1'b1;
    // tick is high in the cycle after div has been all-ones.
    tick_d = &div_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (evt[i]) begin
        // Retrigger wins even when it coincides with tick.
        cnt_d[i] = HOLD_C;
      end else if (tick_q) begin
        cnt_d[i] = sat_dec(cnt_q[i]);
      end
      // Using the next count makes the lamp rise on the sampling edge.
      lamp_d[i] = lamp_test | ((cnt_d[i] != '0) & pwm_gate);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      lamp_q <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      lamp_q <= lamp_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef LAMP_PWM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase_q <= '0;
    else       phase_q <= phase_d;
  end
`endif

  assign lamp = lamp_q;
  assign tick = tick_q;

endmodule
